// File: rtl/mcu_spi_master.sv
// mcu_spi_master: byte-oriented SPI mode-0 initiator standing in for the
// external MCU. Generates SCLK/CSn/MOSI, captures MISO on the falling SCLK
// edge and synchronises the core's active-low interrupt into clk32.
//
// Handshake: a byte is taken on any clk32 edge where start=1 and ready=1
// (tx_data and last are sampled on that same edge); a start while ready=0
// is dropped, never queued. rx_valid is a one-cycle pulse with no back-pressure.
module mcu_spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       last,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       irq,
    output logic       mcu_sclk,
    output logic       mcu_csn,
    output logic       mcu_mosi,
    input  logic       mcu_miso,
    input  logic       mcu_intn
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    // Only the bits still to be sent live here; the bit on the wire is mosi_q.
    logic [6:0] tx_sr_q, tx_sr_d;
    // Seven bits collected so far; the eighth comes straight from MISO.
    logic [6:0] rx_sr_q, rx_sr_d;
    logic       last_q, last_d;
    // Set during the post-byte CSn-low tail of a last byte (runs in LOW).
    logic       tail_q, tail_d;
    logic       sclk_q, sclk_d;
    logic       csn_q, csn_d;
    logic       mosi_q, mosi_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       intn_s1_q, intn_s2_q;

    logic       div_done;
    logic       accept;
    logic       active;

    assign div_done = (div_q == DIV_LAST);
    assign active   = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_HOLD);
    assign ready    = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !abort;
    assign accept   = start && ready;
    assign busy     = (state_q != ST_IDLE);

    assign mcu_sclk = sclk_q;
    assign mcu_csn  = csn_q;
    assign mcu_mosi = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign irq      = ~intn_s2_q;

    // State and datapath registers; everything returns to idle asynchronously.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_sr_q    <= 7'd0;
            rx_sr_q    <= 7'd0;
            last_q     <= 1'b0;
            tail_q     <= 1'b0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            last_q     <= last_d;
            tail_q     <= tail_d;
            sclk_q     <= sclk_d;
            csn_q      <= csn_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt line.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            intn_s1_q <= 1'b1;
            intn_s2_q <= 1'b1;
        end else begin
            intn_s1_q <= mcu_intn;
            intn_s2_q <= intn_s1_q;
        end
    end

    // Next-state and next-output logic: abort beats start, start beats timing.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        last_d     = last_q;
        tail_d     = tail_q;
        sclk_d     = sclk_q;
        csn_d      = csn_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (abort && active) begin
            state_d = ST_GAP;
            div_d   = 8'd0;
            csn_d   = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            tail_d  = 1'b0;
        end else if (accept) begin
            state_d = ST_LOW;
            div_d   = 8'd0;
            bit_d   = 3'd0;
            tx_sr_d = tx_data[6:0];
            mosi_d  = tx_data[7];
            last_d  = last;
            tail_d  = 1'b0;
            csn_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (div_done) begin
                        div_d = 8'd0;
                        if (tail_q) begin
                            csn_d   = 1'b1;
                            tail_d  = 1'b0;
                            state_d = ST_GAP;
                        end else begin
                            sclk_d  = 1'b1;
                            state_d = ST_HIGH;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (div_done) begin
                        div_d   = 8'd0;
                        sclk_d  = 1'b0;
                        rx_sr_d = {rx_sr_q[5:0], mcu_miso};
                        if (bit_q == 3'd7) begin
                            rx_data_d  = {rx_sr_q, mcu_miso};
                            rx_valid_d = 1'b1;
                            if (last_q) begin
                                tail_d  = 1'b1;
                                state_d = ST_LOW;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            mosi_d  = tx_sr_q[6];
                            tx_sr_d = {tx_sr_q[5:0], 1'b0};
                            state_d = ST_LOW;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (div_done) begin
                        div_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: begin
                    // IDLE and HOLD simply wait for an accepted start.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_spi_master.sv
// Directed testbench for mcu_spi_master with a mode-0 SPI target model,
// an rx scoreboard and per-transfer timing measurements.
module tb_mcu_spi_master;

    localparam int CLK_DIV = 2;

    logic       clk32 = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] tx_data;
    logic       last;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       irq;
    logic       mcu_sclk;
    logic       mcu_csn;
    logic       mcu_mosi;
    logic       mcu_miso;
    logic       mcu_intn;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] slave_q[$];
    logic       mosi_bits[$];
    logic [7:0] slave_sr = 8'h00;
    logic       csn_prev = 1'b1;
    int         sclk_rises = 0;
    int         csn_rises = 0;
    int         rxv_cnt = 0;

    mcu_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk32    (clk32),
        .reset_n  (reset_n),
        .start    (start),
        .tx_data  (tx_data),
        .last     (last),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .irq      (irq),
        .mcu_sclk (mcu_sclk),
        .mcu_csn  (mcu_csn),
        .mcu_mosi (mcu_mosi),
        .mcu_miso (mcu_miso),
        .mcu_intn (mcu_intn)
    );

    // Clock
    always #5 clk32 = ~clk32;

    // Target model: presents bit7 at CSn fall, shifts on each SCLK fall,
    // reloads the next queued byte after every 8 bits.
    int slave_bits = 0;
    assign mcu_miso = slave_sr[7];
    always @(negedge mcu_csn or posedge mcu_csn or negedge mcu_sclk) begin
        if (!mcu_csn && csn_prev) begin
            slave_sr   = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
            slave_bits = 0;
        end else if (!mcu_csn) begin
            slave_sr   = {slave_sr[6:0], 1'b0};
            slave_bits = slave_bits + 1;
            if (slave_bits == 8) begin
                slave_bits = 0;
                if (slave_q.size() > 0) slave_sr = slave_q.pop_front();
            end
        end
        csn_prev = mcu_csn;
    end

    // MOSI capture at each SCLK rise
    always @(posedge mcu_sclk) begin
        mosi_bits.push_back(mcu_mosi);
        sclk_rises = sclk_rises + 1;
    end

    always @(posedge mcu_csn) csn_rises = csn_rises + 1;

    // rx scoreboard
    always @(negedge clk32) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            if (exp_q.size() == 0) check_eq("rx_unexpected", rx_valid, 1'b0);
            else check_eq("rx_data", rx_data, exp_q.pop_front());
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pop_mosi_byte();
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mosi_bits.size() > 0) b = {b[6:0], mosi_bits.pop_front()};
            else b = {b[6:0], 1'bx};
        end
        return b;
    endfunction

    // Drivers
    task automatic wait_ready(input string tag);
        int n = 0;
        forever begin
            @(negedge clk32);
            if (ready) break;
            n++;
            if (n > 200) begin
                check_eq(tag, ready, 1'b1);
                break;
            end
        end
    endtask

    // Call right after a negedge; start is held for exactly one posedge.
    task automatic send(input logic [7:0] b, input logic l);
        start   = 1'b1;
        tx_data = b;
        last    = l;
        @(posedge clk32);
        #1;
        start = 1'b0;
        last  = 1'b0;
    endtask

    // Cycles (negedges after accept) to CSn low, rx_valid, CSn high, ready.
    task automatic watch(output int k_lo, output int k_rv, output int k_hi, output int k_rdy);
        k_lo = -1; k_rv = -1; k_hi = -1; k_rdy = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk32);
            if (k_lo < 0 && !mcu_csn) k_lo = k;
            if (k_rv < 0 && rx_valid) k_rv = k;
            if (k_lo >= 0 && k_hi < 0 && mcu_csn) k_hi = k;
            if (k_hi >= 0 && k_rdy < 0 && ready) k_rdy = k;
        end
    endtask

    task automatic wait_rises(input int base, input int n, input string tag);
        int t = 0;
        while (sclk_rises - base < n) begin
            @(negedge clk32);
            t++;
            if (t > 100) begin
                check_eq(tag, sclk_rises - base, n);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_lo, k_rv, k_hi, k_rdy, k, r0, c0, v0;

        reset_n  = 1'b0;
        start    = 1'b0;
        tx_data  = 8'h00;
        last     = 1'b0;
        abort    = 1'b0;
        mcu_intn = 1'b1;
        #23;
        check_eq("rst_sclk", mcu_sclk, 1'b0);
        check_eq("rst_csn", mcu_csn, 1'b1);
        check_eq("rst_mosi", mcu_mosi, 1'b0);
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_irq", irq, 1'b0);
        @(negedge clk32);
        reset_n = 1'b1;
        repeat (2) @(negedge clk32);

        // Single byte, loopback A5 out / 3C back
        slave_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        r0 = sclk_rises; v0 = rxv_cnt;
        wait_ready("t1_ready_timeout");
        send(8'hA5, 1'b1);
        watch(k_lo, k_rv, k_hi, k_rdy);
        check_eq("t1_csn_fall", k_lo, 1);
        check_eq("t1_rxv_after_csn", k_rv - k_lo, 16 * CLK_DIV);
        check_eq("t1_csn_rise", k_hi - k_rv, CLK_DIV);
        check_eq("t1_ready_back", k_rdy - k_hi, CLK_DIV);
        check_eq("t1_total", k_rdy, 1 + 18 * CLK_DIV);
        check_eq("t1_mosi", pop_mosi_byte(), 8'hA5);
        check_eq("t1_rises", sclk_rises - r0, 8);
        check_eq("t1_rxv_count", rxv_cnt - v0, 1);

        // Three-byte burst
        slave_q.push_back(8'h11); slave_q.push_back(8'h22); slave_q.push_back(8'h33);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        r0 = sclk_rises; c0 = csn_rises; v0 = rxv_cnt;
        wait_ready("t2_ready0_timeout");
        send(8'h01, 1'b0);
        wait_ready("t2_hold1_timeout");
        check_eq("t2_hold_csn", mcu_csn, 1'b0);
        check_eq("t2_hold_sclk", mcu_sclk, 1'b0);
        send(8'h02, 1'b0);
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk32);
            if (k < 0 && mcu_sclk) k = i;
        end
        check_eq("t2_b2b_first_rise", k, CLK_DIV + 1);
        wait_ready("t2_hold2_timeout");
        check_eq("t2_csn_stayed_low", csn_rises - c0, 0);
        send(8'h03, 1'b1);
        watch(k_lo, k_rv, k_hi, k_rdy);
        check_eq("t2_csn_rises", csn_rises - c0, 1);
        check_eq("t2_rises", sclk_rises - r0, 24);
        check_eq("t2_rxv_count", rxv_cnt - v0, 3);
        check_eq("t2_mosi0", pop_mosi_byte(), 8'h01);
        check_eq("t2_mosi1", pop_mosi_byte(), 8'h02);
        check_eq("t2_mosi2", pop_mosi_byte(), 8'h03);

        // Start while busy is dropped
        slave_q.push_back(8'h96); exp_q.push_back(8'h96);
        r0 = sclk_rises; v0 = rxv_cnt;
        wait_ready("t3_ready_timeout");
        send(8'hC3, 1'b1);
        repeat (9) @(negedge clk32);
        check_eq("t3_not_ready", ready, 1'b0);
        start = 1'b1; tx_data = 8'hFF; last = 1'b1;
        @(negedge clk32);
        start = 1'b0; last = 1'b0;
        wait_ready("t3_done_timeout");
        repeat (20) @(negedge clk32);
        check_eq("t3_rises", sclk_rises - r0, 8);
        check_eq("t3_mosi", pop_mosi_byte(), 8'hC3);
        check_eq("t3_rxv_count", rxv_cnt - v0, 1);
        check_eq("t3_idle", busy, 1'b0);

        // Abort after the 4th SCLK rise
        slave_q.push_back(8'hE7);
        r0 = sclk_rises; v0 = rxv_cnt;
        wait_ready("t4_ready_timeout");
        send(8'h81, 1'b1);
        wait_rises(r0, 4, "t4_rise_timeout");
        abort = 1'b1;
        @(posedge clk32);
        #1;
        abort = 1'b0;
        check_eq("t4_csn", mcu_csn, 1'b1);
        check_eq("t4_sclk", mcu_sclk, 1'b0);
        check_eq("t4_mosi", mcu_mosi, 1'b0);
        check_eq("t4_gap_not_ready", ready, 1'b0);
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk32);
            if (k < 0 && ready) k = i;
        end
        check_eq("t4_ready_after_gap", k, CLK_DIV + 1);
        repeat (30) @(negedge clk32);
        check_eq("t4_no_rxv", rxv_cnt - v0, 0);
        check_eq("t4_rises", sclk_rises - r0, 4);
        mosi_bits.delete();

        // Interrupt synchroniser
        @(negedge clk32);
        mcu_intn = 1'b0;
        k = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk32);
            if (k < 0 && irq) k = i;
        end
        check_eq("t5_irq_set_lat", (k >= 1) && (k <= 3), 1'b1);
        mcu_intn = 1'b1;
        k = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk32);
            if (k < 0 && !irq) k = i;
        end
        check_eq("t5_irq_clr_lat", (k >= 1) && (k <= 3), 1'b1);

        // Async reset during HIGH of bit 5, then a fresh transfer
        slave_q.push_back(8'h00);
        r0 = sclk_rises;
        wait_ready("t6_ready_timeout");
        send(8'h12, 1'b1);
        wait_rises(r0, 5, "t6_rise_timeout");
        check_eq("t6_in_high", mcu_sclk, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_csn", mcu_csn, 1'b1);
        check_eq("t6_rst_sclk", mcu_sclk, 1'b0);
        check_eq("t6_rst_mosi", mcu_mosi, 1'b0);
        check_eq("t6_rst_busy", busy, 1'b0);
        @(negedge clk32);
        @(negedge clk32);
        reset_n = 1'b1;
        mosi_bits.delete();
        slave_q.delete();
        slave_q.push_back(8'hA7); exp_q.push_back(8'hA7);
        r0 = sclk_rises; v0 = rxv_cnt;
        wait_ready("t6_ready2_timeout");
        send(8'h5A, 1'b1);
        watch(k_lo, k_rv, k_hi, k_rdy);
        check_eq("t6_rxv_after_csn", k_rv - k_lo, 16 * CLK_DIV);
        check_eq("t6_total", k_rdy, 1 + 18 * CLK_DIV);
        check_eq("t6_mosi", pop_mosi_byte(), 8'h5A);
        check_eq("t6_rxv_count", rxv_cnt - v0, 1);

        repeat (5) @(negedge clk32);
        check_eq("rx_missing", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
